// File: rtl/uart_rx_ctrl_if.sv
// Control/status bundle between the UART RX frame sequencer and its datapath
// (line input, checker results, counters, enables and frame-result strobes).
interface uart_rx_ctrl_if #(
    parameter int PRE_W = 6
);
    logic             RX_IN;
    logic [PRE_W-1:0] Prescale;
    logic             PAR_EN;
    logic             sampled_bit;
    logic             strt_glitch;
    logic             par_err;
    logic             stp_err;

    logic [PRE_W-1:0] edge_cnt;
    logic [3:0]       bit_cnt;
    logic             samp_en;
    logic             deser_en;
    logic             strt_chk_en;
    logic             par_chk_en;
    logic             stp_chk_en;
    logic             busy;
    logic             DATA_VALID;
    logic             frm_par_err;
    logic             frm_stp_err;

    // Datapath side: drives the line and checker results, observes the sequencer.
    modport master (
        output RX_IN, Prescale, PAR_EN, sampled_bit, strt_glitch, par_err, stp_err,
        input  edge_cnt, bit_cnt, samp_en, deser_en, strt_chk_en, par_chk_en,
               stp_chk_en, busy, DATA_VALID, frm_par_err, frm_stp_err
    );

    // Sequencer side.
    modport slave (
        input  RX_IN, Prescale, PAR_EN, sampled_bit, strt_glitch, par_err, stp_err,
        output edge_cnt, bit_cnt, samp_en, deser_en, strt_chk_en, par_chk_en,
               stp_chk_en, busy, DATA_VALID, frm_par_err, frm_stp_err
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART RX frame sequencer: edge/bit counters, IDLE/START/DATA/PARITY/STOP walk,
// enables are combinational from state; frame-result strobes land 1 CLK after stop check, no backpressure.
module uart_rx_ctrl #(
    parameter int DATA_W = 8,
    parameter int PRE_W  = 6
) (
    input  logic          CLK,
    input  logic          RST,
    uart_rx_ctrl_if.slave rx_if
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [3:0]       LAST_BIT = 4'(DATA_W - 1);
    localparam logic [PRE_W-1:0] ONE      = PRE_W'(1);
    localparam logic [PRE_W-1:0] MIN_PRE  = PRE_W'(8);

    state_t           state_q, state_d;
    logic [PRE_W-1:0] edge_q, edge_d;
    logic [3:0]       bit_q, bit_d;
    logic [PRE_W-1:0] p_q, p_d;
    logic             p_en_q, p_en_d;
    logic             pe_q, pe_d;
    logic             dv_q, dv_d;
    logic             fpe_q, fpe_d;
    logic             fse_q, fse_d;

    logic [PRE_W-1:0] half;
    logic [PRE_W-1:0] chk_pt;
    logic [PRE_W-1:0] edge_inc;
    logic             at_cp;
    logic             at_end;
    logic             pres_ok;
    logic             samp_en;
    logic             deser_en;
    logic             strt_chk_en;
    logic             par_chk_en;
    logic             stp_chk_en;

    // All bit timing is derived from the Prescale latched at start detect.
    assign half     = p_q >> 1;
    assign chk_pt   = half + PRE_W'(2);
    assign at_cp    = (edge_q == chk_pt);
    assign at_end   = (edge_q == p_q - ONE);
    assign edge_inc = at_end ? '0 : edge_q + ONE;
    assign pres_ok  = !rx_if.Prescale[0] && (rx_if.Prescale >= MIN_PRE);

    always_comb begin
        state_d     = state_q;
        edge_d      = edge_inc;
        bit_d       = bit_q;
        p_d         = p_q;
        p_en_d      = p_en_q;
        pe_d        = pe_q;
        dv_d        = 1'b0;
        fpe_d       = 1'b0;
        fse_d       = 1'b0;
        deser_en    = 1'b0;
        strt_chk_en = 1'b0;
        par_chk_en  = 1'b0;
        stp_chk_en  = 1'b0;

        case (state_q)
            S_IDLE: begin
                edge_d = '0;
                bit_d  = '0;
                // The detect cycle itself counts as edge 0 of the start bit.
                if (!rx_if.RX_IN && pres_ok) begin
                    state_d = S_START;
                    edge_d  = ONE;
                    p_d     = rx_if.Prescale;
                    p_en_d  = rx_if.PAR_EN;
                    pe_d    = 1'b0;
                end
            end
            S_START: begin
                strt_chk_en = at_cp;
                if (at_cp && rx_if.strt_glitch) begin
                    state_d = S_IDLE;
                    edge_d  = '0;
                end else if (at_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                deser_en = at_cp;
                if (at_end) begin
                    if (bit_q == LAST_BIT) begin
                        state_d = p_en_q ? S_PARITY : S_STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                par_chk_en = at_cp;
                if (at_cp && rx_if.par_err) begin
                    pe_d = 1'b1;
                end
                if (at_end) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                stp_chk_en = at_cp;
                // Leave early so a start edge late in the stop bit is still caught.
                if (at_cp) begin
                    state_d = S_IDLE;
                    edge_d  = '0;
                    dv_d    = !pe_q && !rx_if.stp_err;
                    fpe_d   = pe_q;
                    fse_d   = rx_if.stp_err;
                end
            end
            default: begin
                state_d = S_IDLE;
                edge_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    assign samp_en = (state_q != S_IDLE) &&
                     ((edge_q == half - ONE) || (edge_q == half) || (edge_q == half + ONE));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            edge_q  <= '0;
            bit_q   <= '0;
            p_q     <= '0;
            p_en_q  <= 1'b0;
            pe_q    <= 1'b0;
            dv_q    <= 1'b0;
            fpe_q   <= 1'b0;
            fse_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            edge_q  <= edge_d;
            bit_q   <= bit_d;
            p_q     <= p_d;
            p_en_q  <= p_en_d;
            pe_q    <= pe_d;
            dv_q    <= dv_d;
            fpe_q   <= fpe_d;
            fse_q   <= fse_d;
        end
    end

    assign rx_if.edge_cnt    = edge_q;
    assign rx_if.bit_cnt     = bit_q;
    assign rx_if.samp_en     = samp_en;
    assign rx_if.deser_en    = deser_en;
    assign rx_if.strt_chk_en = strt_chk_en;
    assign rx_if.par_chk_en  = par_chk_en;
    assign rx_if.stp_chk_en  = stp_chk_en;
    assign rx_if.busy        = (state_q != S_IDLE);
    assign rx_if.DATA_VALID  = dv_q;
    assign rx_if.frm_par_err = fpe_q;
    assign rx_if.frm_stp_err = fse_q;

    a_strobe_excl: assert property (@(posedge CLK) disable iff (!RST)
        $onehot0({deser_en, strt_chk_en, par_chk_en, stp_chk_en}));

    a_result_excl: assert property (@(posedge CLK) disable iff (!RST)
        !(dv_q && (fpe_q || fse_q)));

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: drives whole serial frames and compares every
// enable/result strobe against frame-level timing predicted from P and PAR_EN.
module tb_uart_rx_ctrl;
    localparam int DATA_W = 8;
    localparam int PRE_W  = 6;

    // Event kinds in the scoreboard (event code = cycle*16 + kind).
    localparam int K_DESER = 0, K_STRT = 1, K_PAR = 2, K_STP = 3;
    localparam int K_DV = 4, K_FPE = 5, K_FSE = 6, K_SAMP = 7, K_OVL = 15;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    uart_rx_ctrl_if #(.PRE_W(PRE_W)) bus ();

    uart_rx_ctrl #(.DATA_W(DATA_W), .PRE_W(PRE_W)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .rx_if (bus)
    );

    assign bus.sampled_bit = bus.RX_IN;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int exp_q[$];
    int obs_q[$];
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d (cyc %0d kind %0d) expected %0d (cyc %0d kind %0d)",
                      tag, obs, obs >>> 4, obs & 15, exp, exp >>> 4, exp & 15);
    endtask

    // Observed strobes, sampled mid-cycle.
    always @(negedge CLK) begin
        if (RST) begin
            if (int'(bus.deser_en) + int'(bus.strt_chk_en) + int'(bus.par_chk_en) +
                int'(bus.stp_chk_en) > 1) obs_q.push_back(cyc * 16 + K_OVL);
            if (bus.samp_en)     obs_q.push_back(cyc * 16 + K_SAMP);
            if (bus.deser_en)    obs_q.push_back(cyc * 16 + K_DESER);
            if (bus.strt_chk_en) obs_q.push_back(cyc * 16 + K_STRT);
            if (bus.par_chk_en)  obs_q.push_back(cyc * 16 + K_PAR);
            if (bus.stp_chk_en)  obs_q.push_back(cyc * 16 + K_STP);
            if (bus.DATA_VALID)  obs_q.push_back(cyc * 16 + K_DV);
            if (bus.frm_par_err) obs_q.push_back(cyc * 16 + K_FPE);
            if (bus.frm_stp_err) obs_q.push_back(cyc * 16 + K_FSE);
        end
    end

    // Frame-level reference: bit b of the frame occupies cycles t0+b*P .. t0+b*P+P-1.
    task automatic model_frame(input int t0, input int p, input bit pen,
                               input bit gl, input bit pe, input bit se);
        int h, cp, nbits, bs, kind;
        h     = p / 2;
        cp    = h + 2;
        nbits = gl ? 1 : (DATA_W + 2 + int'(pen));
        for (int b = 0; b < nbits; b++) begin
            bs = t0 + b * p;
            for (int k = -1; k <= 1; k++) exp_q.push_back((bs + h + k) * 16 + K_SAMP);
            if (b == 0)                 kind = K_STRT;
            else if (b <= DATA_W)       kind = K_DESER;
            else if (b == nbits - 1)    kind = K_STP;
            else                        kind = K_PAR;
            exp_q.push_back((bs + cp) * 16 + kind);
        end
        if (!gl) begin
            bs = t0 + (nbits - 1) * p + cp + 1;
            if (!(pen && pe) && !se) exp_q.push_back(bs * 16 + K_DV);
            if (pen && pe)           exp_q.push_back(bs * 16 + K_FPE);
            if (se)                  exp_q.push_back(bs * 16 + K_FSE);
        end
    endtask

    task automatic compare_events(input string tag);
        while (exp_q.size() > 0 && obs_q.size() > 0)
            chk(tag, obs_q.pop_front(), exp_q.pop_front());
        chk({tag, "_extra_events"}, obs_q.size(), 0);
        chk({tag, "_missing_events"}, exp_q.size(), 0);
        obs_q.delete();
        exp_q.delete();
    endtask

    // Entered and left at #1 after a rising edge.
    task automatic hold(input logic v, input int n);
        for (int k = 0; k < n; k++) begin
            bus.RX_IN = v;
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},     int'(bus.busy), 0);
        chk({tag, "_edge_cnt"}, int'(bus.edge_cnt), 0);
        chk({tag, "_bit_cnt"},  int'(bus.bit_cnt), 0);
        chk({tag, "_strobes"},  int'({bus.samp_en, bus.deser_en, bus.strt_chk_en,
                                      bus.par_chk_en, bus.stp_chk_en}), 0);
        chk({tag, "_results"},  int'({bus.DATA_VALID, bus.frm_par_err, bus.frm_stp_err}), 0);
    endtask

    task automatic abort_frame(input int p, input int bit_idx);
        chk("pre_rst_busy",    int'(bus.busy), 1);
        chk("pre_rst_bit_cnt", int'(bus.bit_cnt), bit_idx);
        chk("pre_rst_edge",    int'(bus.edge_cnt), p / 2);
        RST = 1'b0;
        #1;
        check_all_zero("mid_rst");
        while (exp_q.size() > 0 && (exp_q[$] >>> 4) >= cyc) void'(exp_q.pop_back());
        hold(1'b1, 3);
        RST = 1'b1;
    endtask

    task automatic frame(input int p, input bit pen, input logic [7:0] d, input bit gl,
                         input bit pe, input bit se, input int gap,
                         input int abort_bit, input int mid_p);
        int t0;
        bus.Prescale    = PRE_W'(p);
        bus.PAR_EN      = pen;
        bus.strt_glitch = gl;
        bus.par_err     = pe;
        bus.stp_err     = se;
        t0 = cyc;
        if ((p % 2 == 0) && (p >= 8)) model_frame(t0, p, pen, gl, pe, se);
        if (gl) begin
            hold(1'b0, 2);
            hold(1'b1, 4 * p + gap);
            return;
        end
        hold(1'b0, p);
        for (int i = 0; i < DATA_W; i++) begin
            if (i == abort_bit) begin
                hold(d[i], p / 2);
                abort_frame(p, i);
                return;
            end
            if (i == 2 && mid_p != 0) bus.Prescale = PRE_W'(mid_p);
            hold(d[i], p);
        end
        if (pen) hold(^d, p);
        hold(1'b1, p - 1 + gap);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks so far %0d", n_chk);
        $fatal(1);
    end

    initial begin
        int p, gap;
        bit pen, pe, se, gl;
        bus.RX_IN = 1'b1;
        bus.Prescale = PRE_W'(8);
        bus.PAR_EN = 1'b0;
        bus.strt_glitch = 1'b0;
        bus.par_err = 1'b0;
        bus.stp_err = 1'b0;
        RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_all_zero("reset");
        RST = 1'b1;
        hold(1'b1, 4);

        frame(8, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 10, -1, 0);
        compare_events("t1_p8_a5");
        chk("t1_busy_after", int'(bus.busy), 0);

        frame(16, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 10, -1, 0);
        frame(16, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 10, -1, 0);
        compare_events("t2_par_err_then_clean");

        frame(32, 1'b0, 8'h96, 1'b0, 1'b0, 1'b1, 10, -1, 0);
        compare_events("t3_stop_err");

        frame(8, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 10, -1, 0);
        compare_events("t4_glitch");
        chk("t4_busy_after", int'(bus.busy), 0);

        frame(8, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0, 0, -1, 16);
        frame(16, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0, 10, -1, 0);
        compare_events("t5_back_to_back");

        frame(7, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5, -1, 0);
        frame(6, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 5, -1, 0);
        compare_events("illegal_prescale");
        chk("illegal_busy", int'(bus.busy), 0);

        frame(62, 1'b1, 8'hE7, 1'b0, 1'b1, 1'b1, 10, -1, 0);
        compare_events("p62_both_errors");

        frame(8, 1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 0, 4, 0);
        hold(1'b1, 3);
        frame(8, 1'b0, 8'h4E, 1'b0, 1'b0, 1'b0, 10, -1, 0);
        compare_events("t6_reset_mid_frame");

        for (int n = 0; n < 12; n++) begin
            p   = 2 * $urandom_range(4, 31);
            pen = 1'($urandom_range(0, 1));
            pe  = ($urandom_range(0, 3) == 0);
            se  = ($urandom_range(0, 3) == 0);
            gl  = ($urandom_range(0, 7) == 0);
            gap = $urandom_range(0, 5);
            frame(p, pen, 8'($urandom), gl, pe, se, gap, -1, 0);
        end
        hold(1'b1, 10);
        compare_events("random_frames");
        chk("final_busy", int'(bus.busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
